// File: rtl/cnn_pkg.sv
// Shared types and helpers for the streaming convolution engine.
package cnn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Config word index of the bias register for a KxK kernel.
  function automatic int cfg_bias_idx(input int k);
    return k * k;
  endfunction

  localparam int CFG_BIAS_IDX = cfg_bias_idx(3);

  // Smallest accumulator width that holds a full-precision KxK sum of products.
  function automatic int acc_min_width(input int dw, input int ww, input int k);
    return dw + ww + 1 + $clog2(k * k);
  endfunction

endpackage

// File: rtl/cnn_line_buffer.sv
// (K-1) rows of IMG_W pixels; each write returns the K-tall column ending at the new pixel.
module cnn_line_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int K          = 3,
  parameter int IMG_W      = 28
) (
  input  logic                          clk,
  input  logic                          we_i,
  input  logic [$clog2(IMG_W)-1:0]      col_i,
  input  logic [DATA_WIDTH-1:0]         data_i,
  output logic [DATA_WIDTH-1:0]         col_o [K]
);

  logic [DATA_WIDTH-1:0] mem_q [K-1][IMG_W];

  // col_o[0] is the current row, col_o[K-1] the oldest row.
  always_comb begin
    col_o[0] = data_i;
    for (int j = 1; j < K; j++) col_o[j] = mem_q[j-1][col_i];
  end

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[0][col_i] <= data_i;
      for (int j = 1; j < K - 1; j++) mem_q[j][col_i] <= mem_q[j-1][col_i];
    end
  end

endmodule

// File: rtl/cnn_conv_stream.sv
// Streaming KxK convolution with ReLU and a two-stage MAC pipeline.
// Optional bias register is compiled in with CNN_CONV_BIAS_EN.
module cnn_conv_stream
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int WGT_WIDTH  = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int K          = 3,
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cfg_we,
  input  logic [$clog2(K*K+1)-1:0]     cfg_addr,
  input  logic [31:0]                  cfg_wdata,
  input  logic                         start,
  input  logic                         relu_en,
  output logic                         busy,
  output logic                         done,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [DATA_WIDTH-1:0]        s_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [ACC_WIDTH-1:0]         m_data,
  output logic                         m_last
);

  localparam int AW       = $clog2(K*K+1);
  localparam int CW       = $clog2(IMG_W);
  localparam int RW       = $clog2(IMG_H+1);
  localparam int PW       = DATA_WIDTH + WGT_WIDTH + 1;
  localparam int SUM_W    = acc_min_width(DATA_WIDTH, WGT_WIDTH, K);
  localparam int BIAS_IDX = cfg_bias_idx(K);

  state_e                       state_q;
  logic                         busy_q, done_q, relu_q;
  logic [CW-1:0]                col_q;
  logic [RW-1:0]                row_q;
  logic signed [WGT_WIDTH-1:0]  wgt_q [K*K];
  logic [DATA_WIDTH-1:0]        win_q [K][K];
  logic                         win_valid_q, win_last_q;
  logic signed [PW-1:0]         prod_q [K*K];
  logic                         s1_valid_q, s1_last_q;
  logic                         m_valid_q, m_last_q;
  logic signed [ACC_WIDTH-1:0]  m_data_q;

  logic [DATA_WIDTH-1:0]        col_px [K];
  logic                         advance, pix_hs, last_px, win_ok;
  logic signed [SUM_W-1:0]      sum_full;
  logic signed [ACC_WIDTH-1:0]  bias, result;

  // Valid/ready: a transfer happens on a rising edge where valid && ready; the producer
  // holds data stable until then. The whole pipeline moves only when stage 2 can empty.
  assign advance = !m_valid_q || m_ready;
  assign s_ready = (state_q == RUN) && advance;
  assign pix_hs  = s_valid && s_ready;
  assign last_px = (row_q == RW'(IMG_H-1)) && (col_q == CW'(IMG_W-1));
  assign win_ok  = (row_q >= RW'(K-1)) && (col_q >= CW'(K-1));

  assign busy    = busy_q;
  assign done    = done_q;
  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;
  assign m_data  = m_data_q;

  cnn_line_buffer #(.DATA_WIDTH(DATA_WIDTH), .K(K), .IMG_W(IMG_W)) u_line_buffer (
    .clk    (clk),
    .we_i   (pix_hs),
    .col_i  (col_q),
    .data_i (s_data),
    .col_o  (col_px)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      relu_q  <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: if (start) begin
          state_q <= RUN;
          busy_q  <= 1'b1;
          relu_q  <= relu_en;
          col_q   <= '0;
          row_q   <= '0;
        end
        RUN: if (pix_hs) begin
          if (col_q == CW'(IMG_W-1)) begin
            col_q <= '0;
            row_q <= row_q + RW'(1);
          end else begin
            col_q <= col_q + CW'(1);
          end
          if (last_px) state_q <= DRAIN;
        end
        DRAIN: if (m_valid_q && m_ready && m_last_q) begin
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < K*K; i++) wgt_q[i] <= '0;
    end else if (cfg_we && !busy_q) begin
      for (int i = 0; i < K*K; i++)
        if (cfg_addr == AW'(i)) wgt_q[i] <= cfg_wdata[WGT_WIDTH-1:0];
    end
  end

`ifdef CNN_CONV_BIAS_EN
  logic signed [ACC_WIDTH-1:0] bias_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bias_q <= '0;
    else if (cfg_we && !busy_q && cfg_addr == AW'(BIAS_IDX)) bias_q <= cfg_wdata[ACC_WIDTH-1:0];
  end
  assign bias = bias_q;
`else
  logic unused_cfg_hi;
  assign unused_cfg_hi = ^cfg_wdata[31:WGT_WIDTH];
  assign bias = '0;
`endif

  always_comb begin
    sum_full = '0;
    for (int i = 0; i < K*K; i++) sum_full = sum_full + SUM_W'(prod_q[i]);
    result = ACC_WIDTH'(sum_full) + bias;
    if (relu_q && result[ACC_WIDTH-1]) result = '0;
  end

  // Window, product and output registers form one lock-step pipeline; bubbles travel as valid=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++) win_q[r][c] <= '0;
      for (int i = 0; i < K*K; i++) prod_q[i] <= '0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      m_data_q    <= '0;
    end else if (advance) begin
      if (pix_hs) begin
        for (int r = 0; r < K; r++) begin
          for (int c = 0; c < K - 1; c++) win_q[r][c] <= win_q[r][c+1];
          win_q[r][K-1] <= col_px[K-1-r];
        end
      end
      win_valid_q <= pix_hs && win_ok;
      win_last_q  <= pix_hs && last_px;
      for (int i = 0; i < K*K; i++)
        prod_q[i] <= PW'($signed({1'b0, win_q[i/K][i%K]})) * PW'(wgt_q[i]);
      s1_valid_q <= win_valid_q;
      s1_last_q  <= win_last_q;
      m_valid_q  <= s1_valid_q;
      m_last_q   <= s1_last_q;
      if (s1_valid_q) m_data_q <= result;
    end
  end

endmodule
